// File: rtl/ram_ctrl.sv
// Single-port controller for an 8-word x 16-bit RAM: write/read requests and a bulk clear.
// Read response appears one cycle after the accept edge (ACCESS then RESP), held until rsp_ready; requests stall while not IDLE.
module ram_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    input  logic        clr_start,
    output logic        busy,
    output logic [2:0]  ram_address,
    output logic [15:0] ram_in,
    output logic        ram_load,
    input  logic [15:0] ram_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [2:0]  addr_q;
    logic [15:0] wdata_q;
    logic        write_q;
    logic [15:0] rdata_q;
    logic [2:0]  cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        ram_load    = 1'b0;
        ram_address = addr_q;
        ram_in      = wdata_q;
        case (state)
            IDLE: begin
                // A pending clear wins over a simultaneous request.
                req_ready = ~clr_start;
                if (clr_start) begin
                    state_d = CLEAR;
                end else if (req_valid) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_load = write_q;
                state_d  = write_q ? IDLE : RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                ram_address = cnt;
                ram_in      = 16'h0000;
                ram_load    = 1'b1;
                if (cnt == 3'd7) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= 3'd0;
            wdata_q <= 16'h0000;
            write_q <= 1'b0;
            rdata_q <= 16'h0000;
            cnt     <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        cnt <= 3'd0;
                    end else if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        write_q <= req_write;
                    end
                end
                ACCESS: begin
                    if (!write_q) begin
                        rdata_q <= ram_out;
                    end
                end
                CLEAR: begin
                    cnt <= (cnt == 3'd7) ? 3'd0 : cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ram_ctrl.sv
module tb_ram_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        clr_start;
    logic        busy;
    logic [2:0]  ram_address;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [15:0] ram_out;

    logic [15:0] mem [8];
    logic [15:0] ref_mem [8];
    logic [15:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural RAM: write on the clock edge, combinational read.
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end
    assign ram_out = mem[ram_address];

    ram_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .clr_start(clr_start), .busy(busy),
        .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load),
        .ram_out(ram_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench one step before the accepting edge.
    task automatic wait_ready();
        int n;
        n = 0;
        #1;
        while (!req_ready && n < 50) begin
            cyc();
            #1;
            n++;
        end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        wait_ready();
        cyc();
        req_valid = 1'b0;
        ref_mem[a] = d;
        #1;
        chk("wr_busy", {31'd0, busy}, 32'd1);
        chk("wr_load", {31'd0, ram_load}, 32'd1);
        chk("wr_addr", {29'd0, ram_address}, {29'd0, a});
        chk("wr_data", {16'd0, ram_in}, {16'd0, d});
        cyc();
        #1;
        chk("wr_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_read(input logic [2:0] a, input int hold);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        rsp_ready = (hold == 0);
        wait_ready();
        cyc();
        req_valid = 1'b0;
        exp_q.push_back(ref_mem[a]);
        #1;
        chk("rd_access_vld", {31'd0, rsp_valid}, 32'd0);
        chk("rd_access_load", {31'd0, ram_load}, 32'd0);
        cyc();
        #1;
        chk("rd_latency_vld", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            chk("rd_hold_vld", {31'd0, rsp_valid}, 32'd1);
            chk("rd_hold_data", {16'd0, rsp_rdata}, {16'd0, exp_q[0]});
            chk("rd_hold_rdy", {31'd0, req_ready}, 32'd0);
            cyc();
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        if (rsp_valid && exp_q.size() > 0) begin
            chk("rd_data", {16'd0, rsp_rdata}, {16'd0, exp_q.pop_front()});
        end else begin
            chk("rd_present", {31'd0, rsp_valid}, 32'd1);
        end
        cyc();
        #1;
        chk("rd_done_idle", {31'd0, busy}, 32'd0);
        chk("rd_done_vld", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 3'd0;
        req_wdata = 16'h0000; rsp_ready = 1'b1; clr_start = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;

        // Reset state
        cyc();
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_vld", {31'd0, rsp_valid}, 32'd0);
        chk("rst_load", {31'd0, ram_load}, 32'd0);
        chk("rst_addr", {29'd0, ram_address}, 32'd0);
        chk("rst_in", {16'd0, ram_in}, 32'd0);
        chk("rst_rdy", {31'd0, req_ready}, 32'd1);
        clr_start = 1'b1;
        #1;
        chk("rst_rdy_clr", {31'd0, req_ready}, 32'd0);
        clr_start = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();

        // Write then read back the same word
        do_write(3'd5, 16'hBEEF);
        do_read(3'd5, 0);

        // Stalled response
        do_read(3'd5, 4);

        // Fill, clear, read back zeros
        for (int i = 0; i < 8; i++) do_write(3'(i), 16'h1111 * 16'(i + 1));
        do_read(3'd3, 0);
        clr_start = 1'b1;
        cyc();
        clr_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("clr_busy", {31'd0, busy}, 32'd1);
            chk("clr_load", {31'd0, ram_load}, 32'd1);
            chk("clr_addr", {29'd0, ram_address}, 32'(i));
            chk("clr_in", {16'd0, ram_in}, 32'd0);
            ref_mem[i] = 16'h0000;
            cyc();
        end
        #1;
        chk("clr_end_busy", {31'd0, busy}, 32'd0);
        chk("clr_end_load", {31'd0, ram_load}, 32'd0);
        for (int i = 0; i < 8; i++) do_read(3'(i), 0);

        // Clear and write requested together: clear first
        do_write(3'd6, 16'h1234);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd2; req_wdata = 16'h00AA;
        clr_start = 1'b1;
        #1;
        chk("prio_rdy", {31'd0, req_ready}, 32'd0);
        cyc();
        clr_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("prio_busy", {31'd0, busy}, 32'd1);
            chk("prio_rdy_clr", {31'd0, req_ready}, 32'd0);
            chk("prio_addr", {29'd0, ram_address}, 32'(i));
            ref_mem[i] = 16'h0000;
            cyc();
        end
        #1;
        chk("prio_idle", {31'd0, busy}, 32'd0);
        chk("prio_rdy_idle", {31'd0, req_ready}, 32'd1);
        cyc();
        req_valid = 1'b0;
        ref_mem[2] = 16'h00AA;
        #1;
        chk("prio_wr_load", {31'd0, ram_load}, 32'd1);
        chk("prio_wr_addr", {29'd0, ram_address}, 32'd2);
        chk("prio_wr_in", {16'd0, ram_in}, 32'h00AA);
        cyc();
        do_read(3'd2, 0);
        do_read(3'd6, 0);

        // Reset during clear at cnt=3
        for (int i = 0; i < 8; i++) do_write(3'(i), 16'hA000 + 16'(i));
        clr_start = 1'b1;
        cyc();
        clr_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ref_mem[i] = 16'h0000;
            cyc();
        end
        #1;
        chk("abort_pre_addr", {29'd0, ram_address}, 32'd3);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_load", {31'd0, ram_load}, 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        for (int i = 0; i < 8; i++) do_read(3'(i), 0);

        // Back-to-back writes with req_valid held
        req_valid = 1'b1; req_write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_addr = 3'(k); req_wdata = 16'h5000 + 16'(k);
            ref_mem[k] = 16'h5000 + 16'(k);
            #1;
            chk("b2b_idle_rdy", {31'd0, req_ready}, 32'd1);
            chk("b2b_idle_load", {31'd0, ram_load}, 32'd0);
            cyc();
            #1;
            chk("b2b_acc_rdy", {31'd0, req_ready}, 32'd0);
            chk("b2b_acc_load", {31'd0, ram_load}, 32'd1);
            chk("b2b_acc_addr", {29'd0, ram_address}, 32'(k));
            cyc();
        end
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) do_read(3'(k), 0);
        do_read(3'd7, 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
